// File: rtl/spi_flash_cmd_seq_if.sv
// Link between the flash command sequencer and spi_master_verb: burst control, write port, read port.
// Pure wiring, no latency. The write port is throttled by m_wr_ready; the read port has no backpressure.
// 'master' is the sequencer's view and 'slave' is the SPI master's view.
interface spi_flash_cmd_seq_if;
    logic        request;
    logic [23:0] req_len;
    logic        busy;
    logic        finish;
    logic        m_wr_en;
    logic [7:0]  m_wr_data;
    logic        m_wr_ready;
    logic        m_rd_vld;
    logic [7:0]  m_rd_data;

    modport master (
        output request, req_len, m_wr_en, m_wr_data,
        input  busy, finish, m_wr_ready, m_rd_vld, m_rd_data
    );

    modport slave (
        input  request, req_len, m_wr_en, m_wr_data,
        output busy, finish, m_wr_ready, m_rd_vld, m_rd_data
    );
endinterface

// File: rtl/spi_flash_cmd_seq.sv
// Turns one flash command descriptor into a single SPI burst: header, payload or fill, header-stripped read-back.
// Latency: request the cycle after acceptance, first push the cycle after busy, read data 1 cycle after m_rd_vld.
// Backpressure: m_wr_ready stalls pushes (and usr_wr_ready); the read path has none; a watchdog aborts stalls.
module spi_flash_cmd_seq #(
    parameter int unsigned TIMEOUT = 4096,
    parameter logic [7:0]  FILL    = 8'hFF
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [23:0] cmd_addr,
    input  logic        cmd_addr_en,
    input  logic [3:0]  cmd_dummy,
    input  logic [15:0] cmd_len,
    input  logic        cmd_dir,
    input  logic [7:0]  usr_wr_data,
    input  logic        usr_wr_valid,
    output logic        usr_wr_ready,
    output logic [7:0]  usr_rd_data,
    output logic        usr_rd_valid,
    output logic        done,
    output logic        err,
    spi_flash_cmd_seq_if.master spi
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIM = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_PAY, S_WAIT} state_t;

    state_t      state_q, state_nxt;
    logic        rst_done_q;
    logic [7:0]  op_q;
    logic [23:0] addr_q;
    logic        aen_q;
    logic [15:0] len_q;
    logic        dir_q;
    logic [4:0]  hdr_len_q;
    logic [16:0] tot_q;
    logic [15:0] cnt_q;
    logic [16:0] rd_cnt_q;
    logic        fin_q;
    logic [WDW-1:0] wd_q;
    logic        done_q, err_q;
    logic        rd_vld_q;
    logic [7:0]  rd_dat_q;

    logic        accept;
    logic        push;
    logic [7:0]  wr_byte;
    logic        rd_take;
    logic [16:0] rd_cnt_nxt;
    logic        done_set, err_set;
    logic [4:0]  hdr_len_new;
    logic [16:0] tot_new;

    assign cmd_ready   = rst_done_q && (state_q == S_IDLE);
    assign accept      = cmd_valid && cmd_ready;
    assign rd_take     = spi.m_rd_vld && (state_q != S_IDLE);
    assign rd_cnt_nxt  = rd_cnt_q + {16'b0, rd_take};
    assign hdr_len_new = 5'd1 + (cmd_addr_en ? 5'd3 : 5'd0) + {1'b0, cmd_dummy};
    assign tot_new     = {12'b0, hdr_len_new} + {1'b0, cmd_len};

    assign spi.request   = (state_q == S_REQ);
    assign spi.req_len   = (state_q == S_REQ) ? {4'b0, tot_q, 3'b0} : 24'h0;
    assign spi.m_wr_en   = push;
    assign spi.m_wr_data = wr_byte;
    assign usr_rd_valid  = rd_vld_q;
    assign usr_rd_data   = rd_dat_q;
    assign done          = done_q;
    assign err           = err_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        push         = 1'b0;
        wr_byte      = 8'h00;
        usr_wr_ready = 1'b0;
        done_set     = 1'b0;
        err_set      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (spi.busy) state_nxt = S_HDR;
            end
            S_HDR: begin
                push = spi.m_wr_ready;
                if (cnt_q == 16'd0) begin
                    wr_byte = op_q;
                end else if (aen_q && cnt_q <= 16'd3) begin
                    case (cnt_q[1:0])
                        2'd1:    wr_byte = addr_q[23:16];
                        2'd2:    wr_byte = addr_q[15:8];
                        default: wr_byte = addr_q[7:0];
                    endcase
                end
                if (push && cnt_q == {11'b0, hdr_len_q} - 16'd1)
                    state_nxt = (len_q == 16'd0) ? S_WAIT : S_PAY;
            end
            S_PAY: begin
                wr_byte      = dir_q ? FILL : usr_wr_data;
                usr_wr_ready = !dir_q && spi.m_wr_ready;
                push         = spi.m_wr_ready && (dir_q || usr_wr_valid);
                if (push && cnt_q == len_q - 16'd1) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // finish may coincide with the last read byte, so look at next-cycle values
                if ((fin_q || spi.finish) && rd_cnt_nxt == tot_q) begin
                    state_nxt = S_IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (state_q != S_IDLE && state_nxt == state_q && !push && !spi.m_rd_vld
            && wd_q == WD_LIM) begin
            state_nxt = S_IDLE;
            err_set   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
            op_q       <= 8'h00;
            addr_q     <= 24'h0;
            aen_q      <= 1'b0;
            len_q      <= 16'h0;
            dir_q      <= 1'b0;
            hdr_len_q  <= 5'd0;
            tot_q      <= 17'd0;
            cnt_q      <= 16'd0;
            rd_cnt_q   <= 17'd0;
            fin_q      <= 1'b0;
            wd_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_dat_q   <= 8'h00;
        end else begin
            rst_done_q <= 1'b1;
            done_q     <= done_set;
            err_q      <= err_set;
            if (accept) begin
                op_q      <= cmd_opcode;
                addr_q    <= cmd_addr;
                aen_q     <= cmd_addr_en;
                len_q     <= cmd_len;
                dir_q     <= cmd_dir;
                hdr_len_q <= hdr_len_new;
                tot_q     <= tot_new;
                rd_cnt_q  <= 17'd0;
                fin_q     <= 1'b0;
            end else if (state_q != S_IDLE) begin
                rd_cnt_q <= rd_cnt_nxt;
                if (spi.finish) fin_q <= 1'b1;
            end
            if (state_nxt != state_q) cnt_q <= 16'd0;
            else if (push)            cnt_q <= cnt_q + 16'd1;
            if (state_q == S_IDLE || state_nxt != state_q || push || spi.m_rd_vld)
                wd_q <= '0;
            else
                wd_q <= wd_q + 1'b1;
            rd_vld_q <= rd_take && dir_q && (rd_cnt_q >= {12'b0, hdr_len_q});
            if (rd_take && dir_q && (rd_cnt_q >= {12'b0, hdr_len_q}))
                rd_dat_q <= spi.m_rd_data;
        end
    end

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Bench for spi_flash_cmd_seq: SPI-master stand-in, user stream driver, and a scoreboard built from the
// descriptor (expected MOSI bytes, expected forwarded MISO bytes, req_len) checked every cycle.
module tb_spi_flash_cmd_seq;
    localparam int TIMEOUT = 4096;

    logic        clock;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [23:0] cmd_addr;
    logic        cmd_addr_en;
    logic [3:0]  cmd_dummy;
    logic [15:0] cmd_len;
    logic        cmd_dir;
    logic [7:0]  usr_wr_data;
    logic        usr_wr_valid, usr_wr_ready;
    logic [7:0]  usr_rd_data;
    logic        usr_rd_valid;
    logic        done, err;

    spi_flash_cmd_seq_if spi ();

    spi_flash_cmd_seq #(.TIMEOUT(TIMEOUT), .FILL(8'hFF)) dut (
        .clock(clock), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr), .cmd_addr_en(cmd_addr_en),
        .cmd_dummy(cmd_dummy), .cmd_len(cmd_len), .cmd_dir(cmd_dir),
        .usr_wr_data(usr_wr_data), .usr_wr_valid(usr_wr_valid), .usr_wr_ready(usr_wr_ready),
        .usr_rd_data(usr_rd_data), .usr_rd_valid(usr_rd_valid),
        .done(done), .err(err),
        .spi(spi.master)
    );

    int total = 0;
    int pass  = 0;
    int cyc   = 0;
    int epoch = 0;

    logic [7:0]  miso [64];
    logic [7:0]  wpay [64];
    logic [7:0]  exp_mosi [64];
    logic [7:0]  exp_rd [64];
    logic [7:0]  got_mosi [64];
    logic [7:0]  got_rd [64];
    int          exp_mosi_n, exp_rd_n;
    int          wlen, stall_at, fin_mode, rdy_mode;
    logic [23:0] exp_req_len;

    int          wi, ri, done_cnt, err_cnt, acc_cnt;
    int          done1_cyc, acc2_cyc, last_prog, err_cyc;
    logic [23:0] last_req_len;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "global timeout");
    end

    // SPI master stand-in: one read byte per pushed byte, finish placement selectable
    initial begin : slave
        int s_ep, s_t, pend, rcv;
        logic s_act, fin_sent;
        s_ep = 0; s_t = 0; pend = 0; rcv = 0; s_act = 0; fin_sent = 0;
        spi.busy = 0; spi.finish = 0; spi.m_wr_ready = 0; spi.m_rd_vld = 0; spi.m_rd_data = 0;
        forever begin
            @(negedge clock);
            if (epoch != s_ep) begin
                s_ep = epoch; s_act = 0; pend = 0; rcv = 0; fin_sent = 0;
            end else begin
                if (!s_act && spi.request) begin
                    s_act = 1; s_t = int'(spi.req_len) / 8; pend = 0; rcv = 0; fin_sent = 0;
                end
                if (spi.m_wr_en) pend++;
            end
            @(posedge clock);
            #1;
            spi.finish     = 0;
            spi.m_rd_vld   = 0;
            spi.busy       = s_act;
            spi.m_wr_ready = (rdy_mode == 0) || (cyc % 3 != 2);
            if (s_act) begin
                if (pend > 0 && fin_mode == 2 && rcv == s_t - 1 && !fin_sent) begin
                    spi.finish = 1; fin_sent = 1;
                end else if (pend > 0) begin
                    spi.m_rd_vld  = 1;
                    spi.m_rd_data = (rcv < 64) ? miso[rcv] : 8'h00;
                    rcv++; pend--;
                    if (rcv == s_t && fin_mode == 1) begin
                        spi.finish = 1; fin_sent = 1;
                    end
                end else if (rcv == s_t && !fin_sent) begin
                    spi.finish = 1; fin_sent = 1;
                end
                if (fin_sent && rcv == s_t) s_act = 0;
            end
        end
    end

    initial begin : user_drv
        int u_ep, uidx;
        u_ep = 0; uidx = 0;
        usr_wr_valid = 0; usr_wr_data = 0;
        forever begin
            @(negedge clock);
            if (epoch != u_ep) begin
                u_ep = epoch; uidx = 0;
            end else if (usr_wr_valid && usr_wr_ready) begin
                uidx++;
            end
            @(posedge clock);
            #1;
            usr_wr_valid = (uidx < wlen) && (uidx != stall_at);
            usr_wr_data  = (uidx < 64) ? wpay[uidx] : 8'h00;
        end
    end

    // every-cycle compare against the descriptor-derived model
    initial begin : monitor
        int m_ep;
        m_ep = 0;
        wi = 0; ri = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0;
        done1_cyc = 0; acc2_cyc = 0; last_prog = 0; err_cyc = 0; last_req_len = 0;
        forever begin
            @(negedge clock);
            if (epoch != m_ep) begin
                m_ep = epoch; wi = 0; ri = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0;
                last_req_len = 0;
            end
            if (rst_n) begin
                if (spi.request) begin
                    chk("req_len", 32'(spi.req_len), 32'(exp_req_len));
                    last_req_len = spi.req_len;
                end
                if (spi.m_wr_en) begin
                    chk("wr_en_needs_ready", 32'(spi.m_wr_ready), 32'd1);
                    chk("mosi_in_range", 32'(wi < exp_mosi_n), 32'd1);
                    if (wi < exp_mosi_n) chk("mosi", 32'(spi.m_wr_data), 32'(exp_mosi[wi]));
                    if (wi < 64) got_mosi[wi] = spi.m_wr_data;
                    wi++;
                    last_prog = cyc;
                end
                if (spi.m_rd_vld) last_prog = cyc;
                if (usr_rd_valid) begin
                    chk("rd_in_range", 32'(ri < exp_rd_n), 32'd1);
                    if (ri < exp_rd_n) chk("usr_rd", 32'(usr_rd_data), 32'(exp_rd[ri]));
                    if (ri < 64) got_rd[ri] = usr_rd_data;
                    ri++;
                end
                if (done) begin
                    chk("ready_with_done", 32'(cmd_ready), 32'd1);
                    if (done_cnt == 0) done1_cyc = cyc;
                    done_cnt++;
                end
                if (err) begin
                    if (err_cnt == 0) err_cyc = cyc;
                    err_cnt++;
                end
                if (cmd_valid && cmd_ready) begin
                    acc_cnt++;
                    if (acc_cnt == 2) acc2_cyc = cyc;
                end
            end
        end
    end

    task automatic setup(input logic [7:0] op, input logic [23:0] addr, input logic aen,
                         input int dum, input int len, input logic dir, input int reps,
                         input int fmode, input int rmode, input int stall);
        int h, t, n;
        h = 1 + (aen ? 3 : 0) + dum;
        t = h + len;
        exp_req_len = 24'(t * 8);
        n = 0;
        for (int r = 0; r < reps; r++) begin
            exp_mosi[n] = op; n++;
            if (aen) begin
                exp_mosi[n] = addr[23:16]; exp_mosi[n+1] = addr[15:8]; exp_mosi[n+2] = addr[7:0];
                n += 3;
            end
            for (int i = 0; i < dum; i++) begin exp_mosi[n] = 8'h00; n++; end
            for (int i = 0; i < len; i++) begin exp_mosi[n] = dir ? 8'hFF : wpay[i]; n++; end
        end
        exp_mosi_n = n;
        exp_rd_n = 0;
        if (dir) for (int i = h; i < t; i++) begin exp_rd[exp_rd_n] = miso[i]; exp_rd_n++; end
        wlen = dir ? 0 : len;
        stall_at = stall; fin_mode = fmode; rdy_mode = rmode;
        cmd_opcode = op; cmd_addr = addr; cmd_addr_en = aen;
        cmd_dummy = 4'(dum); cmd_len = 16'(len); cmd_dir = dir;
        epoch++;
        repeat (2) @(posedge clock);
        #2;
    endtask

    task automatic issue();
        int k;
        cmd_valid = 1;
        for (k = 0; k < 20; k++) begin
            @(negedge clock);
            if (cmd_ready) break;
        end
        chk("accept_seen", 32'(k < 20), 32'd1);
        @(posedge clock);
        #2;
        cmd_valid = 0;
    endtask

    task automatic wait_end(input int bound, input int ndone);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clock);
            #1;
            if (done_cnt >= ndone || err_cnt > 0) break;
        end
        chk("end_seen", 32'(done_cnt >= ndone || err_cnt > 0), 32'd1);
        repeat (4) @(negedge clock);
        #1;
    endtask

    task automatic rid_test(input string p);
        miso[0] = 8'hA5; miso[1] = 8'hEF; miso[2] = 8'h40; miso[3] = 8'h18;
        setup(8'h9F, 24'h0, 1'b0, 0, 3, 1'b1, 1, 0, 0, -1);
        issue();
        wait_end(200, 1);
        chk({p, "_req_len"}, 32'(last_req_len), 32'd32);
        chk({p, "_mosi_n"}, 32'(wi), 32'd4);
        chk({p, "_mosi0"}, 32'(got_mosi[0]), 32'h9F);
        chk({p, "_mosi3"}, 32'(got_mosi[3]), 32'hFF);
        chk({p, "_rd_n"}, 32'(ri), 32'd3);
        chk({p, "_rd0"}, 32'(got_rd[0]), 32'hEF);
        chk({p, "_rd1"}, 32'(got_rd[1]), 32'h40);
        chk({p, "_rd2"}, 32'(got_rd[2]), 32'h18);
        chk({p, "_done"}, 32'(done_cnt), 32'd1);
        chk({p, "_no_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin : main
        int k;
        for (int i = 0; i < 64; i++) begin wpay[i] = 8'(8'h80 + i); miso[i] = 8'h00; end
        exp_mosi_n = 0; exp_rd_n = 0; wlen = 0; stall_at = -1; fin_mode = 0; rdy_mode = 0;
        exp_req_len = 0;
        rst_n = 0; cmd_valid = 0; cmd_opcode = 0; cmd_addr = 0; cmd_addr_en = 0;
        cmd_dummy = 0; cmd_len = 0; cmd_dir = 0;

        repeat (3) @(posedge clock);
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_request", 32'(spi.request), 32'd0);
        chk("rst_outs", 32'({spi.m_wr_en, usr_wr_ready, usr_rd_valid, done, err}), 32'd0);
        rst_n = 1;
        @(negedge clock);
        chk("release_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        chk("release_ready_high", 32'(cmd_ready), 32'd1);

        rid_test("rid");

        setup(8'h02, 24'h012345, 1'b1, 0, 4, 1'b0, 1, 1, 1, -1);
        issue();
        wait_end(200, 1);
        chk("pp_req_len", 32'(last_req_len), 32'd64);
        chk("pp_mosi_n", 32'(wi), 32'd8);
        chk("pp_mosi1", 32'(got_mosi[1]), 32'h01);
        chk("pp_mosi2", 32'(got_mosi[2]), 32'h23);
        chk("pp_mosi3", 32'(got_mosi[3]), 32'h45);
        chk("pp_mosi7", 32'(got_mosi[7]), 32'h83);
        chk("pp_no_rd", 32'(ri), 32'd0);
        chk("pp_done", 32'(done_cnt), 32'd1);

        for (int i = 0; i < 64; i++) miso[i] = 8'(8'h10 + i);
        setup(8'h0B, 24'h000000, 1'b1, 1, 2, 1'b1, 1, 2, 0, -1);
        issue();
        wait_end(200, 1);
        chk("fr_req_len", 32'(last_req_len), 32'd56);
        chk("fr_rd_n", 32'(ri), 32'd2);
        chk("fr_rd0", 32'(got_rd[0]), 32'h15);
        chk("fr_rd1", 32'(got_rd[1]), 32'h16);
        chk("fr_done", 32'(done_cnt), 32'd1);

        setup(8'h06, 24'h0, 1'b0, 0, 0, 1'b0, 2, 0, 0, -1);
        cmd_valid = 1;
        for (k = 0; k < 200; k++) begin
            @(negedge clock);
            #1;
            if (acc_cnt >= 2) break;
        end
        @(posedge clock);
        #2;
        cmd_valid = 0;
        wait_end(200, 2);
        chk("we_accepts", 32'(acc_cnt), 32'd2);
        chk("we_req_len", 32'(last_req_len), 32'd8);
        chk("we_mosi_n", 32'(wi), 32'd2);
        chk("we_mosi1", 32'(got_mosi[1]), 32'h06);
        chk("we_done", 32'(done_cnt), 32'd2);
        chk("we_b2b_accept", 32'(acc2_cyc), 32'(done1_cyc));

        setup(8'h02, 24'h000100, 1'b1, 0, 6, 1'b0, 1, 0, 0, 2);
        issue();
        wait_end(TIMEOUT + 300, 1);
        chk("stall_err", 32'(err_cnt), 32'd1);
        chk("stall_no_done", 32'(done_cnt), 32'd0);
        chk("stall_pushed", 32'(wi), 32'd6);
        chk("stall_gap_ok", 32'((err_cyc - last_prog) >= TIMEOUT && (err_cyc - last_prog) <= TIMEOUT + 2), 32'd1);
        chk("stall_ready", 32'(cmd_ready), 32'd1);
        chk("stall_request", 32'(spi.request), 32'd0);

        setup(8'h02, 24'hABCDEF, 1'b1, 0, 12, 1'b0, 1, 0, 0, -1);
        issue();
        for (k = 0; k < 100; k++) begin
            @(negedge clock);
            #1;
            if (wi >= 7) break;
        end
        chk("mid_pay_reached", 32'(wi >= 7), 32'd1);
        @(posedge clock);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_request", 32'(spi.request), 32'd0);
        chk("mid_rst_req_len", 32'(spi.req_len), 32'd0);
        chk("mid_rst_wr", 32'({spi.m_wr_en, spi.m_wr_data}), 32'd0);
        chk("mid_rst_usr", 32'({usr_wr_ready, usr_rd_valid, usr_rd_data}), 32'd0);
        chk("mid_rst_flags", 32'({done, err}), 32'd0);
        repeat (3) @(posedge clock);
        #2;
        rst_n = 1;
        rid_test("rid2");

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
